// File: rtl/sha256_spi_pkg.sv
// Shared types and constants for the SPI host interface of the SHA-256 register file.
package sha256_spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

  // Frame bit index carrying R/W (1 = write); the address follows MSB first.
  localparam int RW_BIT_POS = 0;
  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DATA_W = 8;

  localparam logic [DEF_ADDR_W-1:0] MSG_START_ADDR    = 7'h00;
  localparam logic [DEF_ADDR_W-1:0] STATUS_REG        = 7'h40;
  localparam logic [DEF_ADDR_W-1:0] DIGEST_START_ADDR = 7'h60;

endpackage

// File: rtl/spi_reg_bridge_if.sv
// SPI pins and register strobe bus of the bridge; slave = bridge side, master = host/register side.
interface spi_reg_bridge_if
  import sha256_spi_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              i_sck;
  logic              i_ss_n;
  logic              i_spi_mosi;
  logic              o_spi_miso;
  logic              o_reg_we;
  logic              o_reg_re;
  logic [ADDR_W-1:0] o_reg_addr;
  logic [DATA_W-1:0] o_reg_wdata;
  logic [DATA_W-1:0] i_reg_rdata;
  logic              o_busy;
  logic              o_frame_err;

  modport slave (
    input  i_sck, i_ss_n, i_spi_mosi, i_reg_rdata,
    output o_spi_miso, o_reg_we, o_reg_re, o_reg_addr, o_reg_wdata, o_busy, o_frame_err
  );

  modport master (
    output i_sck, i_ss_n, i_spi_mosi, i_reg_rdata,
    input  o_spi_miso, o_reg_we, o_reg_re, o_reg_addr, o_reg_wdata, o_busy, o_frame_err
  );
endinterface

// File: rtl/spi_sync_edge.sv
// Synchronises sck/ss_n/mosi and produces registered edge pulses; pin edge to pulse is SYNC_STAGES+1 cycles.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sck,
  input  logic ss_n,
  input  logic mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic ss_fall,
  output logic ss_rise,
  output logic mosi_s
);
  logic [SYNC_STAGES-1:0] sck_p0, ss_p0, mosi_p0;
  logic                   sck_p1, ss_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_p0   <= '1;
      ss_p0    <= '1;
      mosi_p0  <= '0;
      sck_p1   <= 1'b1;
      ss_p1    <= 1'b1;
      sck_rise <= 1'b0;
      sck_fall <= 1'b0;
      ss_fall  <= 1'b0;
      ss_rise  <= 1'b0;
      mosi_s   <= 1'b0;
    end else begin
      sck_p0   <= {sck_p0[SYNC_STAGES-2:0], sck};
      ss_p0    <= {ss_p0[SYNC_STAGES-2:0], ss_n};
      mosi_p0  <= {mosi_p0[SYNC_STAGES-2:0], mosi};
      // Edge stage: mosi_s is delayed alongside so it lines up with sck_rise
      sck_p1   <= sck_p0[SYNC_STAGES-1];
      ss_p1    <= ss_p0[SYNC_STAGES-1];
      sck_rise <= sck_p0[SYNC_STAGES-1] & ~sck_p1;
      sck_fall <= ~sck_p0[SYNC_STAGES-1] & sck_p1;
      ss_rise  <= ss_p0[SYNC_STAGES-1] & ~ss_p1;
      ss_fall  <= ~ss_p0[SYNC_STAGES-1] & ss_p1;
      mosi_s   <= mosi_p0[SYNC_STAGES-1];
    end
  end
endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-3 slave to single-cycle register strobe bridge with auto-increment bursts.
// Optional SPI_FRAME_ERR_EN: o_frame_err abort pulse and saturating r_err_cnt.
module spi_reg_bridge
  import sha256_spi_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = 2,
  parameter int AUTO_INC    = 1
) (
  input logic            i_clk,
  input logic            i_rst_n,
  spi_reg_bridge_if.slave bus
);
  localparam int CMD_W = ADDR_W + 1;
  localparam int CNT_W = $clog2((CMD_W > DATA_W ? CMD_W : DATA_W) + 1);

  logic sck_rise, sck_fall, ss_fall, ss_rise, mosi_s;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .sck     (bus.i_sck),
    .ss_n    (bus.i_ss_n),
    .mosi    (bus.i_spi_mosi),
    .sck_rise(sck_rise),
    .sck_fall(sck_fall),
    .ss_fall (ss_fall),
    .ss_rise (ss_rise),
    .mosi_s  (mosi_s)
  );

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic              rw, word_done, rd_load_p1;
  logic [ADDR_W-1:0] cur_addr, cmd_sr, addr_r;
  logic [DATA_W-2:0] rx_sr;
  logic [DATA_W-1:0] tx_sr, wdata_r;
  logic              miso_r, we_r, re_r, busy_r;
  logic [CMD_W-1:0]  cmd_next;
  logic [DATA_W-1:0] rx_next;
  logic              cmd_last, word_last;

  assign cmd_next  = {cmd_sr, mosi_s};
  assign rx_next   = {rx_sr, mosi_s};
  assign cmd_last  = (bit_cnt == CNT_W'(ADDR_W));
  assign word_last = (bit_cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      rw         <= 1'b0;
      word_done  <= 1'b0;
      cur_addr   <= '0;
      rd_load_p1 <= 1'b0;
      miso_r     <= 1'b1;
      we_r       <= 1'b0;
      re_r       <= 1'b0;
      busy_r     <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= '0;
    end else begin
      we_r       <= 1'b0;
      re_r       <= 1'b0;
      rd_load_p1 <= re_r;
      case (state)
        IDLE: if (ss_fall) begin
          state     <= CMD;
          bit_cnt   <= '0;
          word_done <= 1'b0;
          busy_r    <= 1'b1;
          miso_r    <= 1'b1;
        end
        CMD: if (ss_rise) begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end else if (sck_rise) begin
          if (cmd_last) begin
            bit_cnt  <= '0;
            state    <= DATA;
            rw       <= cmd_next[ADDR_W-RW_BIT_POS];
            cur_addr <= cmd_next[ADDR_W-1:0];
            if (!cmd_next[ADDR_W-RW_BIT_POS]) begin
              re_r   <= 1'b1;
              addr_r <= cmd_next[ADDR_W-1:0];
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DATA: if (ss_rise) begin
          state  <= IDLE;
          busy_r <= 1'b0;
          miso_r <= 1'b1;
        end else begin
          if (sck_rise && !word_done) begin
            if (word_last) begin
              bit_cnt <= '0;
              if (rw) begin
                we_r    <= 1'b1;
                addr_r  <= cur_addr;
                wdata_r <= rx_next;
              end
              // Reads prefetch the next word here so the following shift has it ready
              if (AUTO_INC != 0) begin
                cur_addr <= cur_addr + 1'b1;
                if (!rw) begin
                  re_r   <= 1'b1;
                  addr_r <= cur_addr + 1'b1;
                end
              end else begin
                word_done <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          if (sck_fall) miso_r <= (rw || word_done) ? 1'b1 : tx_sr[DATA_W-1];
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shift registers: pure data, no reset needed
  always_ff @(posedge i_clk) begin
    if (rd_load_p1)                    tx_sr <= bus.i_reg_rdata;
    else if (sck_fall && state == DATA) tx_sr <= {tx_sr[DATA_W-2:0], 1'b1};
    if (sck_rise) begin
      cmd_sr <= cmd_next[ADDR_W-1:0];
      rx_sr  <= rx_next[DATA_W-2:0];
    end
  end

`ifdef SPI_FRAME_ERR_EN
  logic       frame_err_r, extra_bits, abort;
  logic [7:0] r_err_cnt;

  assign abort = ss_rise && (state != IDLE) && ((bit_cnt != '0) || extra_bits);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_err_r <= 1'b0;
      extra_bits  <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      frame_err_r <= abort;
      if (abort && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 1'b1;
      if (state == IDLE) extra_bits <= 1'b0;
      else if (state == DATA && word_done && sck_rise) extra_bits <= 1'b1;
    end
  end

  assign bus.o_frame_err = frame_err_r;
`else
  assign bus.o_frame_err = 1'b0;
`endif

  assign bus.o_spi_miso  = miso_r;
  assign bus.o_reg_we    = we_r;
  assign bus.o_reg_re    = re_r;
  assign bus.o_reg_addr  = addr_r;
  assign bus.o_reg_wdata = wdata_r;
  assign bus.o_busy      = busy_r;
endmodule

// File: tb/tb_spi_reg_bridge.sv
// Scoreboard bench for spi_reg_bridge: SPI mode-3 master tasks plus a register-file read model.
module tb_spi_reg_bridge;
  import sha256_spi_pkg::*;

  localparam int AW = 7;
  localparam int DW = 8;

  typedef struct packed {
    logic          is_we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } strobe_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_reg_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  spi_reg_bridge #(.ADDR_W(AW), .DATA_W(DW), .SYNC_STAGES(2), .AUTO_INC(1)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  logic [DW-1:0] mem [0:(1<<AW)-1];
  strobe_t       obs_q[$];
  strobe_t       exp_q[$];
  int            obs_rd = 0;
  int            err_pulses = 0;
  int            overlap = 0;
  int            n_tests = 0;
  int            n_fail = 0;

  // Register file read port: data valid the cycle after o_reg_re
  always @(posedge clk) if (bus.o_reg_re) bus.i_reg_rdata <= mem[bus.o_reg_addr];

  always @(negedge clk) begin
    if (bus.o_reg_we) obs_q.push_back(strobe_t'({1'b1, bus.o_reg_addr, bus.o_reg_wdata}));
    if (bus.o_reg_re) obs_q.push_back(strobe_t'({1'b0, bus.o_reg_addr, 8'h00}));
    if (bus.o_reg_we && bus.o_reg_re) overlap++;
    if (bus.o_frame_err) err_pulses++;
  end

  task automatic spi_bit(input logic b, output logic r);
    bus.i_sck = 1'b0;
    bus.i_spi_mosi = b;
    #80;
    r = bus.o_spi_miso;
    bus.i_sck = 1'b1;
    #80;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], r);
      rx[i] = r;
    end
  endtask

  task automatic spi_begin();
    @(negedge clk);
    bus.i_ss_n = 1'b0;
    #80;
  endtask

  task automatic spi_end();
    #80;
    bus.i_ss_n = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++; if (bus.o_spi_miso !== 1'b1) begin n_fail++; $display("FAIL reset_miso: got %b expected 1", bus.o_spi_miso); end
    n_tests++; if (bus.o_reg_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", bus.o_reg_we); end
    n_tests++; if (bus.o_reg_re !== 1'b0) begin n_fail++; $display("FAIL reset_re: got %b expected 0", bus.o_reg_re); end
    n_tests++; if (bus.o_reg_addr !== 7'h00) begin n_fail++; $display("FAIL reset_addr: got %h expected 00", bus.o_reg_addr); end
    n_tests++; if (bus.o_reg_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_wdata: got %h expected 00", bus.o_reg_wdata); end
    n_tests++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.o_busy); end
    n_tests++; if (bus.o_frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", bus.o_frame_err); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_tests++; if (bus.o_spi_miso !== 1'b1 || bus.o_busy !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: got miso=%b busy=%b expected miso=1 busy=0", bus.o_spi_miso, bus.o_busy);
    end
  endtask

  task automatic test_write_single();
    logic [7:0] rx;
    strobe_t e, o;
    exp_q.push_back(strobe_t'({1'b1, 7'h05, 8'hA5}));
    spi_begin();
    spi_byte({1'b1, 7'h05}, rx);
    n_tests++; if (bus.o_busy !== 1'b1) begin n_fail++; $display("FAIL write_busy_mid: got %b expected 1", bus.o_busy); end
    spi_byte(8'hA5, rx);
    spi_end();
    n_tests++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL write_busy_end: got %b expected 0", bus.o_busy); end
    n_tests++; if (obs_q.size() - obs_rd !== exp_q.size()) begin
      n_fail++; $display("FAIL write_count: got %0d strobes expected %0d", obs_q.size() - obs_rd, exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_rd < obs_q.size()) begin o = obs_q[obs_rd]; obs_rd++; end else o = '1;
      n_tests++; if (o !== e) begin n_fail++; $display("FAIL write_strobe: got %h expected %h", o, e); end
    end
    obs_rd = obs_q.size();
  endtask

  task automatic test_burst_write();
    logic [7:0] rx;
    logic [7:0] wd;
    strobe_t e, o;
    spi_begin();
    spi_byte({1'b1, 7'h7E}, rx);
    for (int i = 0; i < 4; i++) begin
      wd = 8'(8'h11 * (i + 1));
      exp_q.push_back(strobe_t'({1'b1, 7'(7'h7E + i), wd}));
      spi_byte(wd, rx);
    end
    spi_end();
    n_tests++; if (obs_q.size() - obs_rd !== exp_q.size()) begin
      n_fail++; $display("FAIL burst_write_count: got %0d strobes expected %0d", obs_q.size() - obs_rd, exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_rd < obs_q.size()) begin o = obs_q[obs_rd]; obs_rd++; end else o = '1;
      n_tests++; if (o !== e) begin n_fail++; $display("FAIL burst_write_strobe: got %h expected %h", o, e); end
    end
    obs_rd = obs_q.size();
  endtask

  task automatic test_read_single();
    logic [7:0] rx_cmd, rx;
    strobe_t e, o;
    mem[STATUS_REG]      = 8'h3C;
    mem[STATUS_REG + 1]  = 8'h77;
    // Command read plus the next-address prefetch at the end of the word
    exp_q.push_back(strobe_t'({1'b0, STATUS_REG, 8'h00}));
    exp_q.push_back(strobe_t'({1'b0, 7'(STATUS_REG + 1), 8'h00}));
    spi_begin();
    spi_byte({1'b0, STATUS_REG}, rx_cmd);
    spi_byte(8'h00, rx);
    spi_end();
    n_tests++; if (rx_cmd !== 8'hFF) begin n_fail++; $display("FAIL read_cmd_miso: got %h expected ff", rx_cmd); end
    n_tests++; if (rx !== 8'h3C) begin n_fail++; $display("FAIL read_data: got %h expected 3c", rx); end
    n_tests++; if (obs_q.size() - obs_rd !== exp_q.size()) begin
      n_fail++; $display("FAIL read_count: got %0d strobes expected %0d", obs_q.size() - obs_rd, exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_rd < obs_q.size()) begin o = obs_q[obs_rd]; obs_rd++; end else o = '1;
      n_tests++; if (o !== e) begin n_fail++; $display("FAIL read_strobe: got %h expected %h", o, e); end
    end
    obs_rd = obs_q.size();
  endtask

  task automatic test_digest_burst();
    logic [255:0] digest, got;
    logic [7:0]   rx;
    strobe_t e, o;
    digest = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    got = '0;
    for (int i = 0; i < 32; i++) begin
      mem[DIGEST_START_ADDR + i] = digest[255-8*i -: 8];
      exp_q.push_back(strobe_t'({1'b0, 7'(DIGEST_START_ADDR + i), 8'h00}));
    end
    exp_q.push_back(strobe_t'({1'b0, 7'(DIGEST_START_ADDR + 32), 8'h00}));
    spi_begin();
    spi_byte({1'b0, DIGEST_START_ADDR}, rx);
    for (int i = 0; i < 32; i++) begin
      spi_byte(8'h00, rx);
      got[255-8*i -: 8] = rx;
    end
    spi_end();
    n_tests++; if (got !== digest) begin n_fail++; $display("FAIL digest_data: got %h expected %h", got, digest); end
    n_tests++; if (obs_q.size() - obs_rd !== exp_q.size()) begin
      n_fail++; $display("FAIL digest_count: got %0d strobes expected %0d", obs_q.size() - obs_rd, exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_rd < obs_q.size()) begin o = obs_q[obs_rd]; obs_rd++; end else o = '1;
      n_tests++; if (o !== e) begin n_fail++; $display("FAIL digest_strobe: got %h expected %h", o, e); end
    end
    obs_rd = obs_q.size();
  endtask

  task automatic test_abort();
    logic [7:0] rx;
    logic       r;
    int         e0, exp_err;
`ifdef SPI_FRAME_ERR_EN
    exp_err = 2;
`else
    exp_err = 0;
`endif
    e0 = err_pulses;
    // 12 bits of a write frame, then 3 bits of a command
    spi_begin();
    spi_byte({1'b1, 7'h10}, rx);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, r);
    spi_end();
    n_tests++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", bus.o_busy); end
    spi_begin();
    for (int i = 0; i < 3; i++) spi_bit(1'b1, r);
    spi_end();
    n_tests++; if (obs_q.size() !== obs_rd) begin
      n_fail++; $display("FAIL abort_strobes: got %0d strobes expected 0", obs_q.size() - obs_rd);
    end
    n_tests++; if (err_pulses - e0 !== exp_err) begin
      n_fail++; $display("FAIL abort_frame_err: got %0d pulses expected %0d", err_pulses - e0, exp_err);
    end
`ifdef SPI_FRAME_ERR_EN
    n_tests++; if (dut.r_err_cnt !== 8'd2) begin n_fail++; $display("FAIL abort_err_cnt: got %0d expected 2", dut.r_err_cnt); end
`endif
    obs_rd = obs_q.size();
  endtask

  task automatic test_async_reset();
    logic [7:0] rx;
    logic       r;
    strobe_t e, o;
    spi_begin();
    spi_byte({1'b0, DIGEST_START_ADDR}, rx);
    spi_byte(8'h00, rx);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, r);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if (bus.o_spi_miso !== 1'b1) begin n_fail++; $display("FAIL async_rst_miso: got %b expected 1", bus.o_spi_miso); end
    n_tests++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL async_rst_busy: got %b expected 0", bus.o_busy); end
    bus.i_ss_n = 1'b1;
    bus.i_sck  = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    obs_rd = obs_q.size();
    exp_q.push_back(strobe_t'({1'b1, MSG_START_ADDR, 8'h5A}));
    spi_begin();
    spi_byte({1'b1, MSG_START_ADDR}, rx);
    spi_byte(8'h5A, rx);
    spi_end();
    exp_q.push_back(strobe_t'({1'b0, STATUS_REG, 8'h00}));
    exp_q.push_back(strobe_t'({1'b0, 7'(STATUS_REG + 1), 8'h00}));
    spi_begin();
    spi_byte({1'b0, STATUS_REG}, rx);
    spi_byte(8'h00, rx);
    spi_end();
    n_tests++; if (rx !== 8'h3C) begin n_fail++; $display("FAIL after_rst_read: got %h expected 3c", rx); end
    n_tests++; if (obs_q.size() - obs_rd !== exp_q.size()) begin
      n_fail++; $display("FAIL after_rst_count: got %0d strobes expected %0d", obs_q.size() - obs_rd, exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_rd < obs_q.size()) begin o = obs_q[obs_rd]; obs_rd++; end else o = '1;
      n_tests++; if (o !== e) begin n_fail++; $display("FAIL after_rst_strobe: got %h expected %h", o, e); end
    end
    obs_rd = obs_q.size();
    n_tests++; if (overlap !== 0) begin n_fail++; $display("FAIL we_re_overlap: got %0d cycles expected 0", overlap); end
  endtask

  initial begin
    bus.i_sck      = 1'b1;
    bus.i_ss_n     = 1'b1;
    bus.i_spi_mosi = 1'b0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
    test_reset();
    test_write_single();
    test_burst_write();
    test_read_single();
    test_digest_burst();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
